// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and types for the FFT frame scheduler slice.
//   N / NB     : FFT frame length and its counter width
//   DW         : signed sample width (re/im)
//   TAG_W      : width of one in-flight frame tag (source channel)
//   TAG_DEPTH  : default number of frames allowed in flight
//   state_t    : scheduler FSM states
package fft_pkg;

  localparam int unsigned N         = 64;
  localparam int unsigned NB        = $clog2(N);
  localparam int unsigned DW        = 16;
  localparam int unsigned TAG_W     = 1;
  localparam int unsigned TAG_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    STREAM
  } state_t;

endpackage

// File: rtl/fft_frame_sched_if.sv
// fft_frame_sched_if: sample bus between the frame scheduler and corefft.
//   fft_din_en/re/im             : scheduler -> core input samples
//   fft_dout_en/cnt/re/im        : core -> scheduler result bins
// Modports: master = scheduler side, slave = core side.
interface fft_frame_sched_if #(
  parameter int unsigned DW = fft_pkg::DW,
  parameter int unsigned NB = fft_pkg::NB
);

  logic                 fft_din_en;
  logic signed [DW-1:0] fft_din_re;
  logic signed [DW-1:0] fft_din_im;
  logic                 fft_dout_en;
  logic [NB-1:0]        fft_dout_cnt;
  logic signed [DW-1:0] fft_dout_re;
  logic signed [DW-1:0] fft_dout_im;

  modport master (
    output fft_din_en, fft_din_re, fft_din_im,
    input  fft_dout_en, fft_dout_cnt, fft_dout_re, fft_dout_im
  );

  modport slave (
    input  fft_din_en, fft_din_re, fft_din_im,
    output fft_dout_en, fft_dout_cnt, fft_dout_re, fft_dout_im
  );

endinterface

// File: rtl/fft_tag_fifo.sv
// fft_tag_fifo: small synchronous FIFO holding the source-channel tag of
// each frame currently inside the FFT core.
//   clk, areset : clock, synchronous active-high reset (empties the FIFO)
//   push, push_data : write a tag (ignored when full unless popping too)
//   pop         : discard the head tag (ignored when empty)
//   head        : tag at the head of the FIFO
//   full, empty : occupancy flags
// DEPTH must be a power of two >= 2. Push and pop in the same cycle is
// accepted even when full.
module fft_tag_fifo
  import fft_pkg::*;
#(
  parameter int unsigned DEPTH = TAG_DEPTH,
  parameter int unsigned W     = TAG_W
) (
  input  logic         clk,
  input  logic         areset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/fft_frame_sched.sv
// fft_frame_sched: two-channel round-robin frame scheduler in front of a
// 64-point pipelined FFT core. Streams gap-free N-sample frames into the
// core and tags each result frame with its source channel.
//   clk, areset           : clock, synchronous active-high reset
//   ch_req / ch_gnt       : per-channel frame request (level) / grant pulse
//   ch_valid, chX_re/im   : per-channel sample valid and data
//   core (master)         : fft_din_* to the core, fft_dout_* from the core
//   out_valid/ch/idx/sof/eof/re/im : registered, tagged result bins
//   underrun              : sticky zero-fill flag for the current frame
//   err_orphan            : core output seen with no frame in flight
// Build option FFT_SCHED_FRAME_CNT_EN adds per-channel 16-bit completed-
// frame counters on frame_cnt0 / frame_cnt1.
module fft_frame_sched
  import fft_pkg::*;
#(
  parameter int unsigned N         = fft_pkg::N,
  parameter int unsigned DW        = fft_pkg::DW,
  parameter int unsigned TAG_DEPTH = fft_pkg::TAG_DEPTH,
  localparam int unsigned NB       = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic [1:0]           ch_req,
  output logic [1:0]           ch_gnt,
  input  logic [1:0]           ch_valid,
  input  logic signed [DW-1:0] ch0_re,
  input  logic signed [DW-1:0] ch0_im,
  input  logic signed [DW-1:0] ch1_re,
  input  logic signed [DW-1:0] ch1_im,
  fft_frame_sched_if.master    core,
  output logic                 out_valid,
  output logic                 out_ch,
  output logic [NB-1:0]        out_idx,
  output logic                 out_sof,
  output logic                 out_eof,
  output logic signed [DW-1:0] out_re,
  output logic signed [DW-1:0] out_im,
  output logic                 underrun,
  output logic                 err_orphan
`ifdef FFT_SCHED_FRAME_CNT_EN
  ,
  output logic [15:0]          frame_cnt0,
  output logic [15:0]          frame_cnt1
`endif
);

  localparam logic [NB-1:0] LAST_IDX = NB'(N - 1);

  state_t        state;
  state_t        state_nxt;
  logic          sel;
  logic          last_ch;
  logic          pick;
  logic [NB-1:0] in_cnt;
  logic          can_grant;
  logic          tag_push;
  logic          tag_pop;
  logic [TAG_W-1:0] tag_head;
  logic          tag_full;
  logic          tag_empty;

  // A pop in this cycle frees a slot for a grant in the very next cycle.
  assign tag_pop   = core.fft_dout_en && (core.fft_dout_cnt == LAST_IDX);
  assign can_grant = (|ch_req) && (!tag_full || tag_pop);

  always_comb begin
    pick = 1'b0;
    case (ch_req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      2'b11:   pick = ~last_ch;
      default: pick = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ch_gnt    = '0;
    tag_push  = 1'b0;
    case (state)
      IDLE: begin
        if (can_grant) state_nxt = GRANT;
      end
      GRANT: begin
        ch_gnt    = sel ? 2'b10 : 2'b01;
        tag_push  = 1'b1;
        state_nxt = STREAM;
      end
      STREAM: begin
        if (in_cnt == LAST_IDX) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      sel             <= 1'b0;
      last_ch         <= 1'b1;
      in_cnt          <= '0;
      underrun        <= 1'b0;
      core.fft_din_en <= 1'b0;
      core.fft_din_re <= '0;
      core.fft_din_im <= '0;
    end else begin
      core.fft_din_en <= 1'b0;
      core.fft_din_re <= '0;
      core.fft_din_im <= '0;
      case (state)
        IDLE: begin
          if (can_grant) sel <= pick;
        end
        GRANT: begin
          last_ch  <= sel;
          underrun <= 1'b0;
          in_cnt   <= '0;
        end
        STREAM: begin
          core.fft_din_en <= 1'b1;
          in_cnt <= (in_cnt == LAST_IDX) ? '0 : in_cnt + 1'b1;
          if (ch_valid[sel]) begin
            core.fft_din_re <= sel ? ch1_re : ch0_re;
            core.fft_din_im <= sel ? ch1_im : ch0_im;
          end else begin
            underrun <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  fft_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .W     (TAG_W)
  ) u_tag_fifo (
    .clk       (clk),
    .areset    (areset),
    .push      (tag_push),
    .push_data (sel),
    .pop       (tag_pop),
    .head      (tag_head),
    .full      (tag_full),
    .empty     (tag_empty)
  );

  always_ff @(posedge clk) begin
    if (areset) begin
      out_valid  <= 1'b0;
      out_ch     <= 1'b0;
      out_idx    <= '0;
      out_sof    <= 1'b0;
      out_eof    <= 1'b0;
      out_re     <= '0;
      out_im     <= '0;
      err_orphan <= 1'b0;
    end else begin
      out_valid  <= core.fft_dout_en;
      out_ch     <= core.fft_dout_en && !tag_empty && tag_head[0];
      out_idx    <= core.fft_dout_cnt;
      out_sof    <= core.fft_dout_en && (core.fft_dout_cnt == '0);
      out_eof    <= core.fft_dout_en && (core.fft_dout_cnt == LAST_IDX);
      out_re     <= core.fft_dout_re;
      out_im     <= core.fft_dout_im;
      err_orphan <= core.fft_dout_en && tag_empty;
    end
  end

`ifdef FFT_SCHED_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (areset) begin
      frame_cnt0 <= '0;
      frame_cnt1 <= '0;
    end else if (out_valid && out_eof) begin
      if (out_ch) frame_cnt1 <= frame_cnt1 + 1'b1;
      else        frame_cnt0 <= frame_cnt0 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_frame_sched.sv
module tb_fft_frame_sched;
  import fft_pkg::*;

  logic                 clk = 1'b0;
  logic                 areset;
  logic [1:0]           ch_req;
  logic [1:0]           ch_gnt;
  logic [1:0]           ch_valid;
  logic signed [DW-1:0] ch0_re, ch0_im, ch1_re, ch1_im;
  logic                 out_valid, out_ch, out_sof, out_eof;
  logic [NB-1:0]        out_idx;
  logic signed [DW-1:0] out_re, out_im;
  logic                 underrun, err_orphan;
`ifdef FFT_SCHED_FRAME_CNT_EN
  logic [15:0]          frame_cnt0, frame_cnt1;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fft_frame_sched_if #(.DW(DW), .NB(NB)) core_bus ();

  fft_frame_sched #(
    .N         (N),
    .DW        (DW),
    .TAG_DEPTH (4)
  ) dut (
    .clk        (clk),
    .areset     (areset),
    .ch_req     (ch_req),
    .ch_gnt     (ch_gnt),
    .ch_valid   (ch_valid),
    .ch0_re     (ch0_re),
    .ch0_im     (ch0_im),
    .ch1_re     (ch1_re),
    .ch1_im     (ch1_im),
    .core       (core_bus),
    .out_valid  (out_valid),
    .out_ch     (out_ch),
    .out_idx    (out_idx),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .out_re     (out_re),
    .out_im     (out_im),
    .underrun   (underrun),
    .err_orphan (err_orphan)
`ifdef FFT_SCHED_FRAME_CNT_EN
    ,
    .frame_cnt0 (frame_cnt0),
    .frame_cnt1 (frame_cnt1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    areset   = 1'b1;
    ch_req   = '0;
    ch_valid = '0;
    ch0_re = '0; ch0_im = '0; ch1_re = '0; ch1_im = '0;
    core_bus.fft_dout_en  = 1'b0;
    core_bus.fft_dout_cnt = '0;
    core_bus.fft_dout_re  = '0;
    core_bus.fft_dout_im  = '0;
    tick();
    tick();
    areset = 1'b0;
  endtask

  // Returns in the grant cycle, or with timeout set after max_cycles.
  task automatic wait_grant(input int max_cycles, output logic [1:0] g, output bit timeout);
    g = '0;
    timeout = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (ch_gnt != 2'b00) begin
        g = ch_gnt;
        timeout = 1'b0;
        break;
      end
    end
  endtask

  // Plays one result frame from the core side, bins 0..N-1.
  task automatic drive_frame(input int base);
    for (int i = 0; i < N; i++) begin
      core_bus.fft_dout_en  = 1'b1;
      core_bus.fft_dout_cnt = NB'(i);
      core_bus.fft_dout_re  = DW'(base + i);
      core_bus.fft_dout_im  = DW'(-(base + i));
      tick();
    end
    core_bus.fft_dout_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [1:0] g;
    bit to;
    areset   = 1'b1;
    ch_req   = 2'b11;
    ch_valid = 2'b11;
    ch0_re = 16'sd5; ch0_im = '0; ch1_re = 16'sd6; ch1_im = '0;
    core_bus.fft_dout_en  = 1'b0;
    core_bus.fft_dout_cnt = '0;
    core_bus.fft_dout_re  = '0;
    core_bus.fft_dout_im  = '0;
    tick();
    tick();
    n_cmp++;
    if ({ch_gnt, core_bus.fft_din_en, out_valid, out_ch, out_sof, out_eof, underrun, err_orphan} !== 9'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b expected 000000000",
               {ch_gnt, core_bus.fft_din_en, out_valid, out_ch, out_sof, out_eof, underrun, err_orphan});
    end
    n_cmp++;
    if ({core_bus.fft_din_re, core_bus.fft_din_im, out_re, out_im, out_idx} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: din_re=%0d out_re=%0d out_idx=%0d expected all 0",
               core_bus.fft_din_re, out_re, out_idx);
    end
`ifdef FFT_SCHED_FRAME_CNT_EN
    n_cmp++;
    if ({frame_cnt0, frame_cnt1} !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_frame_cnt: got %0d/%0d expected 0/0", frame_cnt0, frame_cnt1);
    end
`endif
    // First tie after reset goes to ch0.
    areset = 1'b0;
    wait_grant(4, g, to);
    ch_req = '0;
    n_cmp++;
    if (to || g !== 2'b01) begin
      n_bad++;
      $display("FAIL first_tie_gnt: got %b timeout=%0d expected 01", g, to);
    end
  endtask

  task automatic test_single_frame();
    logic [1:0] g;
    bit to;
    int en_cnt, data_bad, first_k, last_k;
    do_reset();
    ch_req   = 2'b01;
    ch_valid = 2'b01;
    ch1_re   = 16'sd555;
    ch1_im   = 16'sd555;
    wait_grant(10, g, to);
    ch_req = '0;
    n_cmp++;
    if (to || g !== 2'b01) begin
      n_bad++;
      $display("FAIL single_gnt: got %b timeout=%0d expected 01", g, to);
    end
    en_cnt = 0; data_bad = 0; first_k = -1; last_k = -1;
    for (int k = 1; k <= N + 3; k++) begin
      tick();
      ch0_re = (k <= N) ? DW'(k) : '0;
      ch0_im = (k <= N) ? DW'(2 * k) : '0;
      if (core_bus.fft_din_en) begin
        en_cnt++;
        if (first_k < 0) first_k = k;
        last_k = k;
        if (core_bus.fft_din_re !== DW'(k - 1) || core_bus.fft_din_im !== DW'(2 * (k - 1)))
          data_bad++;
      end
    end
    n_cmp++;
    if (en_cnt != N || first_k != 2 || last_k != N + 1) begin
      n_bad++;
      $display("FAIL single_din_en: cycles=%0d first=G+%0d last=G+%0d expected %0d G+2 G+%0d",
               en_cnt, first_k, last_k, N, N + 1);
    end
    n_cmp++;
    if (data_bad != 0) begin
      n_bad++;
      $display("FAIL single_din_data: %0d bad samples expected 0", data_bad);
    end
    n_cmp++;
    if (underrun !== 1'b0) begin
      n_bad++;
      $display("FAIL single_underrun: got %b expected 0", underrun);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] g;
    bit to;
    int bad;
    logic ch_at_sof;
    do_reset();
    ch_req   = 2'b11;
    ch_valid = 2'b11;
    for (int f = 0; f < 4; f++) begin
      wait_grant(N + 10, g, to);
      n_cmp++;
      if (to || g !== ((f % 2) ? 2'b10 : 2'b01)) begin
        n_bad++;
        $display("FAIL tie_gnt%0d: got %b timeout=%0d expected %b", f, g, to,
                 (f % 2) ? 2'b10 : 2'b01);
      end
    end
    ch_req = '0;
    for (int i = 0; i < N + 4; i++) tick();
    for (int f = 0; f < 4; f++) begin
      bad = 0;
      ch_at_sof = 1'bx;
      for (int i = 0; i < N; i++) begin
        core_bus.fft_dout_en  = 1'b1;
        core_bus.fft_dout_cnt = NB'(i);
        core_bus.fft_dout_re  = DW'(f * N + i);
        core_bus.fft_dout_im  = DW'(-i);
        tick();
        if (i == 0) ch_at_sof = out_ch;
        if (out_valid !== 1'b1 || out_ch !== 1'((f % 2)) || out_idx !== NB'(i) ||
            out_sof !== (i == 0) || out_eof !== (i == N - 1) ||
            out_re !== DW'(f * N + i) || out_im !== DW'(-i) || err_orphan !== 1'b0)
          bad++;
      end
      n_cmp++;
      if (ch_at_sof !== 1'((f % 2))) begin
        n_bad++;
        $display("FAIL tie_out_ch%0d: got %b expected %0d", f, ch_at_sof, f % 2);
      end
      n_cmp++;
      if (bad != 0) begin
        n_bad++;
        $display("FAIL tie_out_frame%0d: %0d bad bins expected 0", f, bad);
      end
    end
    core_bus.fft_dout_en = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL tie_out_idle: out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_underrun();
    logic [1:0] g;
    bit to;
    int en_cnt, data_bad, und_bad, s;
    logic signed [DW-1:0] exp_re;
    do_reset();
    ch_req   = 2'b10;
    ch_valid = 2'b10;
    ch0_re   = 16'sd777;
    wait_grant(10, g, to);
    ch_req = '0;
    n_cmp++;
    if (to || g !== 2'b10) begin
      n_bad++;
      $display("FAIL underrun_gnt: got %b timeout=%0d expected 10", g, to);
    end
    en_cnt = 0; data_bad = 0; und_bad = 0;
    for (int k = 1; k <= N + 3; k++) begin
      tick();
      ch1_re   = DW'(100 + k);
      ch_valid = (k >= 10 && k <= 12) ? 2'b00 : 2'b10;
      s = k - 1;
      if (core_bus.fft_din_en) begin
        en_cnt++;
        exp_re = (s >= 10 && s <= 12) ? '0 : DW'(100 + s);
        if (core_bus.fft_din_re !== exp_re) data_bad++;
      end
      if (underrun !== (k >= 11)) und_bad++;
    end
    n_cmp++;
    if (en_cnt != N) begin
      n_bad++;
      $display("FAIL underrun_len: got %0d cycles expected %0d", en_cnt, N);
    end
    n_cmp++;
    if (data_bad != 0) begin
      n_bad++;
      $display("FAIL underrun_data: %0d bad samples expected 0", data_bad);
    end
    n_cmp++;
    if (und_bad != 0) begin
      n_bad++;
      $display("FAIL underrun_flag: %0d cycles wrong expected 0", und_bad);
    end
    ch_req = 2'b10;
    wait_grant(10, g, to);
    ch_req = '0;
    n_cmp++;
    if (to || underrun !== 1'b1) begin
      n_bad++;
      $display("FAIL underrun_hold: got %b timeout=%0d expected 1 in grant cycle", underrun, to);
    end
    tick();
    n_cmp++;
    if (underrun !== 1'b0) begin
      n_bad++;
      $display("FAIL underrun_clear: got %b expected 0 after grant", underrun);
    end
  endtask

  task automatic test_fifo_full();
    logic [1:0] g;
    bit to;
    int extra, tos;
    do_reset();
    ch_req   = 2'b01;
    ch_valid = 2'b01;
    tos = 0;
    for (int f = 0; f < 4; f++) begin
      wait_grant(N + 10, g, to);
      if (to) tos++;
    end
    n_cmp++;
    if (tos != 0) begin
      n_bad++;
      $display("FAIL full_four_gnts: %0d timeouts expected 0", tos);
    end
    extra = 0;
    for (int i = 0; i < N + 10; i++) begin
      tick();
      if (ch_gnt != 2'b00) extra++;
    end
    for (int i = 0; i < N; i++) begin
      core_bus.fft_dout_en  = 1'b1;
      core_bus.fft_dout_cnt = NB'(i);
      core_bus.fft_dout_re  = DW'(i);
      if (ch_gnt != 2'b00) extra++;
      tick();
    end
    core_bus.fft_dout_en = 1'b0;
    n_cmp++;
    if (extra != 0) begin
      n_bad++;
      $display("FAIL full_blocked: %0d grant cycles while full expected 0", extra);
    end
    n_cmp++;
    if (ch_gnt !== 2'b01) begin
      n_bad++;
      $display("FAIL full_gnt_after_pop: got %b expected 01 one cycle after pop", ch_gnt);
    end
    n_cmp++;
    if (out_eof !== 1'b1 || out_ch !== 1'b0) begin
      n_bad++;
      $display("FAIL full_pop_eof: eof=%b ch=%b expected 1 0", out_eof, out_ch);
    end
    ch_req = '0;
  endtask

  task automatic test_orphan_reset();
    logic [1:0] g;
    bit to;
    do_reset();
    core_bus.fft_dout_en  = 1'b1;
    core_bus.fft_dout_cnt = NB'(5);
    core_bus.fft_dout_re  = 16'sd7;
    tick();
    core_bus.fft_dout_en = 1'b0;
    n_cmp++;
    if ({err_orphan, out_ch, out_valid} !== 3'b101 || out_idx !== NB'(5)) begin
      n_bad++;
      $display("FAIL orphan: err/ch/valid=%b idx=%0d expected 101 5",
               {err_orphan, out_ch, out_valid}, out_idx);
    end
    tick();
    n_cmp++;
    if (err_orphan !== 1'b0) begin
      n_bad++;
      $display("FAIL orphan_pulse: got %b expected 0", err_orphan);
    end
    ch_req   = 2'b01;
    ch_valid = 2'b01;
    ch0_re   = 16'sd9;
    wait_grant(10, g, to);
    ch_req = '0;
    for (int k = 1; k <= 31; k++) tick();
    n_cmp++;
    if (to || core_bus.fft_din_en !== 1'b1 || core_bus.fft_din_re !== 16'sd9) begin
      n_bad++;
      $display("FAIL midframe_stream: en=%b re=%0d timeout=%0d expected 1 9",
               core_bus.fft_din_en, core_bus.fft_din_re, to);
    end
    areset = 1'b1;
    tick();
    n_cmp++;
    if ({core_bus.fft_din_en, ch_gnt, underrun, out_valid, err_orphan} !== 6'b0 ||
        core_bus.fft_din_re !== '0) begin
      n_bad++;
      $display("FAIL midframe_reset: en/gnt/und/val/orph=%b re=%0d expected 0",
               {core_bus.fft_din_en, ch_gnt, underrun, out_valid, err_orphan}, core_bus.fft_din_re);
    end
    areset = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (core_bus.fft_din_en !== 1'b0) begin
      n_bad++;
      $display("FAIL midframe_idle: din_en=%b expected 0 after reset", core_bus.fft_din_en);
    end
  endtask

`ifdef FFT_SCHED_FRAME_CNT_EN
  task automatic test_frame_cnt();
    logic [1:0] g;
    bit to;
    int tos;
    do_reset();
    ch_req   = 2'b11;
    ch_valid = 2'b11;
    tos = 0;
    for (int f = 0; f < 4; f++) begin
      wait_grant(N + 10, g, to);
      if (to) tos++;
    end
    ch_req = '0;
    for (int i = 0; i < N + 4; i++) tick();
    for (int f = 0; f < 4; f++) drive_frame(f * N);
    ch_req = 2'b01;
    wait_grant(10, g, to);
    if (to) tos++;
    ch_req = '0;
    drive_frame(0);
    tick();
    tick();
    n_cmp++;
    if (tos != 0 || frame_cnt0 !== 16'd3 || frame_cnt1 !== 16'd2) begin
      n_bad++;
      $display("FAIL frame_cnt: got %0d/%0d timeouts=%0d expected 3/2", frame_cnt0, frame_cnt1, tos);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_underrun();
    test_fifo_full();
    test_orphan_reset();
`ifdef FFT_SCHED_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d mismatched=%0d", n_cmp, n_bad);
    $fatal(1);
  end

endmodule

// File: doc/fft_frame_sched.md
# fft_frame_sched

Two-channel frame scheduler in front of `corefft` (64-point radix-2 pipelined FFT). It arbitrates two sample sources round-robin and drives the core's `din_en`/`din_re`/`din_im` with gap-free 64-sample frames. It tracks frames in flight with a tag FIFO, so each result frame on `dout_*` leaves tagged with its source channel, bin index and frame markers.

## Interface
- `N`, 64: FFT frame length; must match `corefft`; log2 gives counter width `NB`=6.
- `DW`, 16: sample width (signed, re/im).
- `TAG_DEPTH`, 4: frames allowed in flight inside the core (power of 2).
- `clk`  in  1  system clock; all logic on the rising edge.
- `areset`  in  1  synchronous, active-high reset.
- `ch_req[1:0]`  in  2  per-channel frame request, level.
- `ch_gnt[1:0]`  out  2  one-cycle grant pulse.
- `ch_valid[1:0]`  in  2  per-channel sample valid.
- `ch0_re`, `ch0_im`, `ch1_re`, `ch1_im`  in  DW each  channel samples.
- `fft_din_en`  out  1  to core `din_en`.
- `fft_din_re`, `fft_din_im`  out  DW  to core `din_re`/`din_im`.
- `fft_dout_en`  in  1  from core.
- `fft_dout_cnt`  in  NB  from core.
- `fft_dout_re`, `fft_dout_im`  in  DW  from core.
- `out_valid`  out  1  result valid.
- `out_ch`  out  1  source channel of the current result.
- `out_idx`  out  NB  bin index.
- `out_sof`, `out_eof`  out  1  bin 0 / bin N-1 markers.
- `out_re`, `out_im`  out  DW  result data.
- `underrun`  out  1  sticky for the current input frame; cleared at the next grant.
- `err_orphan`  out  1  one-cycle pulse: core output seen with the tag FIFO empty.

## Operation
- FSM states:
  - IDLE → GRANT: when any `ch_req` is high and the tag FIFO is not full.
  - GRANT → STREAM: always, after one cycle. `ch_gnt[sel]` is high during this cycle, and `sel` is pushed to the tag FIFO.
  - STREAM → IDLE: after N cycles, counted by `in_cnt` 0..N-1.
- Round-robin arbitration:
  - Only one requester: it wins.
  - Both requesting: the channel other than `last_ch` wins.
  - `last_ch` resets to 1, so ch0 wins the first tie.
- STREAM, each cycle:
  - `fft_din_en`=1.
  - If `ch_valid[sel]` is high, data is taken from channel `sel`.
  - Otherwise zeros are inserted and `underrun` is set.
- Every frame is exactly N contiguous cycles.
- A requester must hold `ch_req` until `ch_gnt`. Deasserting it earlier withdraws the request with no effect.
- Tag FIFO:
  - Push at GRANT.
  - Pop when `fft_dout_en` is high and `fft_dout_cnt`==N-1.
  - A simultaneous push and pop leaves the count unchanged.
- Output stage, when `fft_dout_en` is high:
  - `out_ch` = tag FIFO head.
  - `out_idx` = `fft_dout_cnt`.
  - `out_sof` = (cnt==0); `out_eof` = (cnt==N-1).
  - If the FIFO is empty: `out_ch`=0 and `err_orphan` pulses.
- Reset values:
  - All outputs 0; FSM in IDLE; FIFO empty; `in_cnt`=0; `last_ch`=1.
  - `areset` mid-frame aborts the frame immediately: `fft_din_en`=0 on the next cycle. The core must be reset alongside the scheduler.

## Timing
- Grant-to-data:
  - `ch_gnt` pulses in cycle G.
  - The channel sample is presented in cycles G+1..G+N.
  - `fft_din_*` is registered, so it appears in G+2..G+N+1.
- Minimum spacing: 2 idle cycles on `fft_din_en` between frames (GRANT cycle plus the IDLE decision cycle).
- Output latency: `out_*` = `fft_dout_*` delayed by one register.
- FIFO full: no grant until a pop. A pop in cycle P allows GRANT in P+1.

## Configuration
- `FFT_SCHED_FRAME_CNT_EN`, when defined:
  - Adds two 16-bit per-channel completed-frame counters as outputs `frame_cnt0`/`frame_cnt1`.
  - Each increments on `out_eof` for its channel, wraps at 0xFFFF→0 and resets to 0.
- When undefined: the counters and their ports do not exist; all other behaviour is identical.

## Structure
- Package `fft_pkg` holds:
  - `N`, `NB`, `DW` constants.
  - FSM state enum {IDLE, GRANT, STREAM}.
  - Tag width constant.
- Sub-module `fft_tag_fifo`:
  - 1-bit-wide synchronous FIFO, depth `TAG_DEPTH`.
  - Ports: push, pop, head, full, empty.
  - Simultaneous push and pop is allowed when full.

## Test plan
- Single frame: ch0 requests and streams samples 1..64 → `ch_gnt[0]` at G, `fft_din_en` high exactly 64 cycles from G+2, `fft_din_re` = 1..64, `underrun`=0.
- Tie: both channels request continuously → grants alternate 0,1,0,1, and output frames carry `out_ch` 0,1,0,1 with `out_sof` at idx 0 and `out_eof` at idx 63.
- Underrun: ch1 drops `ch_valid` for samples 10..12 → `fft_din_re`=0 in those slots, `underrun`=1 until the next grant, and the frame is still 64 cycles.
- FIFO full: with `TAG_DEPTH`=4 and the core output stalled, 4 grants occur and the 5th waits until the first `out_eof`, granting exactly 1 cycle after the pop.
- Orphan/reset: inject `fft_dout_en` with an empty FIFO → `err_orphan` pulse and `out_ch`=0. Assert `areset` at `in_cnt`=30 → all outputs 0 next cycle and FSM in IDLE.
- `FFT_SCHED_FRAME_CNT_EN`: after 3 ch0 and 2 ch1 result frames → `frame_cnt0`=3, `frame_cnt1`=2.
